// File: rtl/mem_arbiter_if.sv
// Bus bundle between the core (fetch + load/store ports), the arbiter and
// the unified single-port memory.
interface mem_arbiter_if #(
    parameter int ADDR_W = 10
);
    logic              if_req;
    logic [31:0]       if_addr;
    logic              if_ready;
    logic [31:0]       if_rdata;

    logic              d_req;
    logic              d_we;
    logic [1:0]        d_size;
    logic              d_unsigned;
    logic [31:0]       d_addr;
    logic [31:0]       d_wdata;
    logic              d_ready;
    logic [31:0]       d_rdata;
    logic              d_misaligned;

    logic              m_en;
    logic [3:0]        m_we;
    logic [ADDR_W-1:0] m_addr;
    logic [31:0]       m_wdata;
    logic [31:0]       m_rdata;

    // Arbiter side
    modport slave (
        input  if_req, if_addr, d_req, d_we, d_size, d_unsigned, d_addr, d_wdata, m_rdata,
        output if_ready, if_rdata, d_ready, d_rdata, d_misaligned, m_en, m_we, m_addr, m_wdata
    );

    // Core + memory side
    modport master (
        output if_req, if_addr, d_req, d_we, d_size, d_unsigned, d_addr, d_wdata, m_rdata,
        input  if_ready, if_rdata, d_ready, d_rdata, d_misaligned, m_en, m_we, m_addr, m_wdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// Arbiter/sequencer for the unified code/data memory: one access per grant,
// data priority with a bounded run before a waiting fetch is forced in.
//
// state  | meaning
// IDLE   | evaluate grant; misaligned data goes straight to DONE
// ACCESS | m_en high, store lanes driven
// RESP   | capture m_rdata, extend load data
// DONE   | one-cycle ready pulse to the granted requester
module mem_arbiter #(
    parameter int ADDR_W       = 10,
    parameter int MAX_DATA_RUN = 4
) (
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.slave  bus
);
    localparam int RUN_W = $clog2(MAX_DATA_RUN + 1);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP, DONE} state_t;

    state_t           state;
    logic [RUN_W-1:0] run_cnt;
    logic             gnt_data;
    logic             lat_we;
    logic             lat_uns;
    logic [1:0]       lat_size;
    logic [1:0]       lat_lo;

    logic             d_misalign;
    logic             take_data;
    logic [3:0]       st_we;
    logic [31:0]      st_wdata;
    logic [7:0]       ld_byte;
    logic [15:0]      ld_half;
    logic [31:0]      ld_data;

    // Address bits outside the word index are intentionally ignored.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{bus.if_addr[31:ADDR_W+2], bus.if_addr[1:0],
                                bus.d_addr[31:ADDR_W+2]};

    // Grant decision, alignment check and store lane steering from the live request.
    always_comb begin
        d_misalign = 1'b0;
        st_we      = 4'b1111;
        st_wdata   = bus.d_wdata;
        case (bus.d_size)
            2'b00: begin
                st_we    = 4'b0001 << bus.d_addr[1:0];
                st_wdata = {4{bus.d_wdata[7:0]}};
            end
            2'b01: begin
                d_misalign = bus.d_addr[0];
                st_we      = 4'b0011 << {bus.d_addr[1], 1'b0};
                st_wdata   = {2{bus.d_wdata[15:0]}};
            end
            2'b10:   d_misalign = |bus.d_addr[1:0];
            default: d_misalign = 1'b1;
        endcase
        // A waiting fetch only preempts data once the run limit is reached.
        take_data = bus.d_req && (!bus.if_req || run_cnt != RUN_W'(MAX_DATA_RUN));
    end

    // Lane select and sign/zero extension of the returned word for loads.
    always_comb begin
        ld_byte = bus.m_rdata[{lat_lo, 3'b000} +: 8];
        ld_half = bus.m_rdata[{lat_lo[1], 4'b0000} +: 16];
        case (lat_size)
            2'b00:   ld_data = {{24{~lat_uns & ld_byte[7]}}, ld_byte};
            2'b01:   ld_data = {{16{~lat_uns & ld_half[15]}}, ld_half};
            default: ld_data = bus.m_rdata;
        endcase
    end

    // Sequencer FSM with all memory and response outputs registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= IDLE;
            run_cnt          <= '0;
            gnt_data         <= 1'b0;
            lat_we           <= 1'b0;
            lat_uns          <= 1'b0;
            lat_size         <= 2'b00;
            lat_lo           <= 2'b00;
            bus.m_en         <= 1'b0;
            bus.m_we         <= 4'b0000;
            bus.m_addr       <= '0;
            bus.m_wdata      <= '0;
            bus.if_ready     <= 1'b0;
            bus.if_rdata     <= '0;
            bus.d_ready      <= 1'b0;
            bus.d_rdata      <= '0;
            bus.d_misaligned <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (!bus.if_req) run_cnt <= '0;
                    if (take_data) begin
                        // take_data with if_req high implies run_cnt < MAX, so no overflow.
                        if (bus.if_req) run_cnt <= run_cnt + 1'b1;
                        gnt_data <= 1'b1;
                        lat_we   <= bus.d_we;
                        lat_uns  <= bus.d_unsigned;
                        lat_size <= bus.d_size;
                        lat_lo   <= bus.d_addr[1:0];
                        if (d_misalign) begin
                            bus.d_ready      <= 1'b1;
                            bus.d_misaligned <= 1'b1;
                            bus.d_rdata      <= '0;
                            state            <= DONE;
                        end else begin
                            bus.m_en    <= 1'b1;
                            bus.m_addr  <= bus.d_addr[ADDR_W+1:2];
                            bus.m_we    <= bus.d_we ? st_we : 4'b0000;
                            bus.m_wdata <= st_wdata;
                            state       <= ACCESS;
                        end
                    end else if (bus.if_req) begin
                        run_cnt    <= '0;
                        gnt_data   <= 1'b0;
                        lat_we     <= 1'b0;
                        bus.m_en   <= 1'b1;
                        bus.m_addr <= bus.if_addr[ADDR_W+1:2];
                        bus.m_we   <= 4'b0000;
                        state      <= ACCESS;
                    end
                end
                ACCESS: begin
                    bus.m_en <= 1'b0;
                    bus.m_we <= 4'b0000;
                    state    <= RESP;
                end
                RESP: begin
                    if (gnt_data) begin
                        bus.d_rdata      <= lat_we ? 32'h0 : ld_data;
                        bus.d_ready      <= 1'b1;
                        bus.d_misaligned <= 1'b0;
                    end else begin
                        bus.if_rdata <= bus.m_rdata;
                        bus.if_ready <= 1'b1;
                    end
                    state <= DONE;
                end
                default: begin
                    bus.if_ready     <= 1'b0;
                    bus.d_ready      <= 1'b0;
                    bus.d_misaligned <= 1'b0;
                    state            <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus randomized single-requester
// traffic, checked against a byte-level shadow memory.
module tb_mem_arbiter;
    localparam int ADDR_W  = 10;
    localparam int MAX_RUN = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vectors     = 0;
    int   miscompares = 0;

    mem_arbiter_if #(.ADDR_W(ADDR_W)) bus ();

    mem_arbiter #(.ADDR_W(ADDR_W), .MAX_DATA_RUN(MAX_RUN)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Memory array as seen by the arbiter: read data lands the cycle after m_en.
    logic [31:0] mem     [1024];
    logic [31:0] ref_mem [1024];

    always @(posedge clk) begin
        if (bus.m_en) begin
            bus.m_rdata <= mem[bus.m_addr];
            for (int b = 0; b < 4; b++)
                if (bus.m_we[b]) mem[bus.m_addr][b*8 +: 8] = bus.m_wdata[b*8 +: 8];
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_m_en"}, 32'(bus.m_en), 0);
        check({tag, "_m_we"}, 32'(bus.m_we), 0);
        check({tag, "_m_addr"}, 32'(bus.m_addr), 0);
        check({tag, "_m_wdata"}, bus.m_wdata, 0);
        check({tag, "_if_ready"}, 32'(bus.if_ready), 0);
        check({tag, "_if_rdata"}, bus.if_rdata, 0);
        check({tag, "_d_ready"}, 32'(bus.d_ready), 0);
        check({tag, "_d_rdata"}, bus.d_rdata, 0);
        check({tag, "_d_misal"}, 32'(bus.d_misaligned), 0);
    endtask

    // Reference: value a load returns, from the shadow memory.
    function automatic logic [31:0] ref_load(input logic [31:0] addr, input logic [1:0] size,
                                             input logic uns);
        logic [31:0] w;
        logic [31:0] v;
        w = ref_mem[addr[11:2]];
        if (size == 2'd0) begin
            v = (w >> (addr[1:0] * 8)) & 32'hFF;
            if (!uns && v >= 32'd128) v = v + 32'hFFFF_FF00;
        end else if (size == 2'd1) begin
            v = (w >> (addr[1] * 16)) & 32'hFFFF;
            if (!uns && v >= 32'd32768) v = v + 32'hFFFF_0000;
        end else begin
            v = w;
        end
        return v;
    endfunction

    function automatic bit ref_misaligned(input logic [31:0] addr, input logic [1:0] size);
        if (size == 2'd3) return 1'b1;
        return (addr % (32'd1 << size)) != 0;
    endfunction

    function automatic int lane_start(input logic [31:0] addr, input logic [1:0] size);
        if (size == 2'd0) return int'(addr[1:0]);
        if (size == 2'd1) return int'(addr[1]) * 2;
        return 0;
    endfunction

    task automatic ref_store(input logic [31:0] addr, input logic [1:0] size, input logic [31:0] data);
        int idx;
        int n;
        int start;
        idx   = int'(addr[11:2]);
        n     = 1 << size;
        start = lane_start(addr, size);
        for (int k = 0; k < n; k++) ref_mem[idx][(start + k)*8 +: 8] = data[k*8 +: 8];
    endtask

    // One data transaction; returns observed d_rdata.
    task automatic data_txn(input logic we, input logic [1:0] size, input logic uns,
                            input logic [31:0] addr, input logic [31:0] wdata,
                            output logic [31:0] got);
        bit          mis;
        int          n;
        int          lat;
        bit          seen_en;
        bit          seen_if;
        logic [31:0] exp_rd;
        logic [3:0]  exp_we;
        logic [31:0] exp_wd;
        mis     = ref_misaligned(addr, size);
        n       = 1 << size;
        exp_rd  = (we || mis) ? 32'h0 : ref_load(addr, size, uns);
        exp_we  = we ? 4'(((1 << n) - 1) << lane_start(addr, size)) : 4'h0;
        exp_wd  = (n == 1) ? wdata[7:0] * 32'h0101_0101 :
                  (n == 2) ? wdata[15:0] * 32'h0001_0001 : wdata;
        lat     = 0;
        seen_en = 0;
        seen_if = 0;
        got     = 'x;
        bus.d_req      = 1'b1;
        bus.d_we       = we;
        bus.d_size     = size;
        bus.d_unsigned = uns;
        bus.d_addr     = addr;
        bus.d_wdata    = wdata;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (k == 1 && !mis) begin
                check("d_m_en", 32'(bus.m_en), 1);
                check("d_m_addr", 32'(bus.m_addr), 32'(addr[11:2]));
                check("d_m_we", 32'(bus.m_we), 32'(exp_we));
                if (we) check("d_m_wdata", bus.m_wdata, exp_wd);
            end
            if (bus.m_en) seen_en = 1;
            if (bus.if_ready) seen_if = 1;
            if (bus.d_ready) begin
                lat = k;
                break;
            end
        end
        check("d_latency", lat, mis ? 1 : 3);
        if (lat != 0) begin
            got = bus.d_rdata;
            check("d_misaligned", 32'(bus.d_misaligned), 32'(mis));
            check("d_rdata", bus.d_rdata, exp_rd);
        end
        check("d_no_if_ready", 32'(seen_if), 0);
        if (mis) check("d_misal_no_m_en", 32'(seen_en), 0);
        bus.d_req = 1'b0;
        if (we && !mis) ref_store(addr, size, wdata);
        @(negedge clk);
    endtask

    task automatic fetch_txn(input logic [31:0] addr);
        int lat;
        bit seen_d;
        lat    = 0;
        seen_d = 0;
        bus.if_req  = 1'b1;
        bus.if_addr = addr;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (k == 1) begin
                check("f_m_en", 32'(bus.m_en), 1);
                check("f_m_addr", 32'(bus.m_addr), 32'(addr[11:2]));
                check("f_m_we", 32'(bus.m_we), 0);
            end
            if (bus.d_ready) seen_d = 1;
            if (bus.if_ready) begin
                lat = k;
                break;
            end
        end
        check("f_latency", lat, 3);
        if (lat != 0) check("f_rdata", bus.if_rdata, ref_mem[addr[11:2]]);
        check("f_no_d_ready", 32'(seen_d), 0);
        bus.if_req = 1'b0;
        @(negedge clk);
    endtask

    logic [31:0] got;
    logic [31:0] v;
    int          grants;
    bit          seen;

    initial begin
        bus.if_req = 0; bus.if_addr = 0;
        bus.d_req = 0; bus.d_we = 0; bus.d_size = 0; bus.d_unsigned = 0;
        bus.d_addr = 0; bus.d_wdata = 0;
        for (int i = 0; i < 1024; i++) begin
            v = 32'(i) * 32'h9E37_79B1 + 32'h0123_4567;
            mem[i] = v;
            ref_mem[i] = v;
        end
        mem[4] = 32'hDEAD_BEEF; ref_mem[4] = 32'hDEAD_BEEF;
        mem[8] = 32'h80F1_7F00; ref_mem[8] = 32'h80F1_7F00;

        // Reset state
        #12;
        check_outputs_zero("reset");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Fetch
        fetch_txn(32'h0000_0010);

        // Byte / half loads
        data_txn(0, 2'd0, 0, 32'h21, 0, got); check("lb_21", got, 32'h0000_007F);
        data_txn(0, 2'd0, 0, 32'h22, 0, got); check("lb_22", got, 32'hFFFF_FFF1);
        data_txn(0, 2'd0, 1, 32'h23, 0, got); check("lbu_23", got, 32'h0000_0080);
        data_txn(0, 2'd1, 0, 32'h22, 0, got); check("lh_22", got, 32'hFFFF_80F1);

        // Stores then merged readback
        data_txn(1, 2'd0, 0, 32'h31, 32'h0000_00AB, got);
        data_txn(1, 2'd1, 0, 32'h32, 32'h0000_1234, got);
        data_txn(0, 2'd2, 0, 32'h30, 0, got);

        // Misaligned word load, then confirm the word is intact
        data_txn(0, 2'd2, 0, 32'h42, 0, got);
        data_txn(0, 2'd2, 0, 32'h40, 0, got);

        // Both requesters held: D,D,D,D,F repeating
        bus.if_req = 1; bus.if_addr = 32'h0000_0010;
        bus.d_req = 1; bus.d_we = 0; bus.d_size = 2'd2; bus.d_unsigned = 0; bus.d_addr = 32'h20;
        grants = 0;
        for (int k = 0; k < 80 && grants < 10; k++) begin
            @(negedge clk);
            if (bus.if_ready || bus.d_ready) begin
                grants++;
                if (grants % (MAX_RUN + 1) == 0) begin
                    check("arb_who", {30'd0, bus.if_ready, bus.d_ready}, 32'b10);
                    check("arb_f_data", bus.if_rdata, ref_mem[4]);
                end else begin
                    check("arb_who", {30'd0, bus.if_ready, bus.d_ready}, 32'b01);
                    check("arb_d_data", bus.d_rdata, ref_mem[8]);
                end
            end
        end
        check("arb_grants", grants, 10);
        bus.if_req = 0; bus.d_req = 0;
        @(negedge clk);
        @(negedge clk);

        // Reset during the ACCESS cycle of a word store
        bus.d_req = 1; bus.d_we = 1; bus.d_size = 2'd2; bus.d_unsigned = 0;
        bus.d_addr = 32'h50; bus.d_wdata = 32'hCAFE_F00D;
        @(negedge clk);
        check("rst_access_m_en", 32'(bus.m_en), 1);
        check("rst_access_m_we", 32'(bus.m_we), 32'hF);
        #1 rst = 1'b1;
        #1 check_outputs_zero("rst_mid");
        bus.d_req = 0;
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (bus.d_ready || bus.if_ready) seen = 1;
        end
        check("rst_no_ready", 32'(seen), 0);
        data_txn(0, 2'd2, 0, 32'h50, 0, got);
        check("rst_mem_kept", got, mem[20]);

        // Randomized single-requester traffic
        for (int t = 0; t < 60; t++) begin
            logic [31:0] a;
            a = ($urandom & 32'hFFFF_F000) | (32'($urandom_range(0, 63)) << 2)
                | 32'($urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0)
                fetch_txn(a);
            else
                data_txn(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                         1'($urandom_range(0, 1)), a, $urandom, got);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
